// File: rtl/wb_cp0_unit.sv
// Write-back stage with an extended CP0: retires results into the register file and HI/LO,
// takes exceptions and interrupts, runs the Count/Compare timer and exports retired destinations.
module wb_cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0000,
  parameter int          N_INT      = 6,
  parameter int          HIST_DEPTH = 2,
  parameter int          TIMER_EN   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wb_valid,
  input  logic                    wb_wen,
  input  logic [4:0]              wb_wdest,
  input  logic [31:0]             wb_result,
  input  logic [31:0]             wb_lo_result,
  input  logic                    hi_write,
  input  logic                    lo_write,
  input  logic                    mfhi,
  input  logic                    mflo,
  input  logic                    mfc0,
  input  logic                    mtc0,
  input  logic [7:0]              cp0_addr,
  input  logic                    exc_in,
  input  logic [4:0]              exc_code_in,
  input  logic [31:0]             bad_vaddr,
  input  logic                    eret,
  input  logic [31:0]             wb_pc,
  input  logic [N_INT-1:0]        int_in,
  output logic                    rf_wen,
  output logic [4:0]              rf_wdest,
  output logic [31:0]             rf_wdata,
  output logic                    exc_valid,
  output logic [31:0]             exc_pc,
  output logic                    cancel,
  output logic [5*HIST_DEPTH-1:0] hist_dest,
  output logic [31:0]             hi_data,
  output logic [31:0]             lo_data,
  output logic                    int_pending
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0]                 r_hi, r_lo, r_epc, r_badVaddr, r_count, r_compare;
  logic                        r_ie, r_exl, r_ti, r_wrapped;
  logic [N_INT-1:0]            r_im, r_ip;
  logic [4:0]                  r_excCode;
  logic [HIST_DEPTH-1:0][4:0]  r_hist;

  logic                        w_intTake, w_trap, w_eretTake, w_retire, w_mtc0, w_sel0;
  logic                        w_timerMatch;
  logic [4:0]                  w_trapCode, w_cp0Reg;
  logic [31:0]                 w_status, w_cause, w_cp0Rdata;
  logic [N_INT-1:0]            w_ipNext;

  assign w_cp0Reg    = cp0_addr[7:3];
  assign w_sel0      = (cp0_addr[2:0] == 3'd0);
  assign int_pending = r_ie & ~r_exl & (|(r_ip & r_im));
  assign w_intTake   = wb_valid & int_pending;
  assign w_trap      = w_intTake | (wb_valid & exc_in);
  assign w_eretTake  = wb_valid & ~w_trap & eret;
  assign w_retire    = wb_valid & ~w_trap & ~eret;
  assign w_mtc0      = w_retire & mtc0 & w_sel0;
  assign w_trapCode  = w_intTake ? 5'd0 : exc_code_in;

  // Compare == 0 only matches once Count has wrapped, so reset does not fire the timer.
  assign w_timerMatch = (TIMER_EN != 0) && (r_count == r_compare) &&
                        ((r_compare != 32'd0) || r_wrapped);

  always_comb begin
    w_ipNext = int_in;
    w_ipNext[N_INT-1] = int_in[N_INT-1] | r_ti;
  end

  always_comb begin
    w_status = '0;
    w_status[0] = r_ie;
    w_status[1] = r_exl;
    w_status[8 +: N_INT] = r_im;
    w_cause = '0;
    w_cause[30] = r_ti;
    w_cause[8 +: N_INT] = r_ip;
    w_cause[6:2] = r_excCode;
    w_cp0Rdata = '0;
    if (w_sel0) begin
      case (w_cp0Reg)
        REG_BADVADDR: w_cp0Rdata = r_badVaddr;
        REG_COUNT:    w_cp0Rdata = r_count;
        REG_COMPARE:  w_cp0Rdata = r_compare;
        REG_STATUS:   w_cp0Rdata = w_status;
        REG_CAUSE:    w_cp0Rdata = w_cause;
        REG_EPC:      w_cp0Rdata = r_epc;
        default:      w_cp0Rdata = '0;
      endcase
    end
  end

  assign rf_wen    = resetn & w_retire & wb_wen;
  assign rf_wdest  = wb_wdest;
  assign rf_wdata  = mfhi ? r_hi : mflo ? r_lo : mfc0 ? w_cp0Rdata : wb_result;
  assign exc_valid = resetn & (w_trap | w_eretTake);
  assign cancel    = exc_valid;
  assign exc_pc    = w_trap ? EXC_VECTOR : r_epc;
  assign hist_dest = r_hist;
  assign hi_data   = r_hi;
  assign lo_data   = r_lo;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_epc      <= '0;
      r_badVaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_ti       <= 1'b0;
      r_wrapped  <= 1'b0;
      r_im       <= '0;
      r_ip       <= '0;
      r_excCode  <= '0;
      r_hist     <= '0;
    end else begin
      r_ip <= w_ipNext;
      r_hist[0] <= (rf_wen && (wb_wdest != 5'd0)) ? wb_wdest : 5'd0;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        r_hist[k] <= r_hist[k-1];
      end

      if (w_retire && hi_write) r_hi <= wb_result;
      if (w_retire && lo_write) r_lo <= wb_lo_result;

      if (TIMER_EN != 0) begin
        if (w_mtc0 && (w_cp0Reg == REG_COUNT)) begin
          r_count <= wb_result;
        end else begin
          r_count <= r_count + 32'd1;
          if (r_count == 32'hFFFF_FFFF) r_wrapped <= 1'b1;
        end
        if (w_mtc0 && (w_cp0Reg == REG_COMPARE)) begin
          r_compare <= wb_result;
          r_ti      <= 1'b0;
        end else if (w_timerMatch) begin
          r_ti <= 1'b1;
        end
      end

      // A trap suppresses any mtc0 carried by the same instruction.
      if (w_trap) begin
        r_epc     <= wb_pc;
        r_exl     <= 1'b1;
        r_excCode <= w_trapCode;
        if ((w_trapCode == 5'd4) || (w_trapCode == 5'd5)) r_badVaddr <= bad_vaddr;
      end else if (w_eretTake) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (w_cp0Reg)
          REG_STATUS: begin
            r_ie  <= wb_result[0];
            r_exl <= wb_result[1];
            r_im  <= wb_result[8 +: N_INT];
          end
          REG_CAUSE: r_excCode <= wb_result[6:2];
          REG_EPC:   r_epc     <= wb_result;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_cp0_unit.sv
// Self-checking bench for wb_cp0_unit: scenario tasks push expected read/history values
// into scoreboard queues and compare them as the DUT produces each result.
module tb_wb_cp0_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_wdest;
  logic [31:0] wb_result, wb_lo_result;
  logic        hi_write, lo_write, mfhi, mflo, mfc0, mtc0;
  logic [7:0]  cp0_addr;
  logic        exc_in;
  logic [4:0]  exc_code_in;
  logic [31:0] bad_vaddr;
  logic        eret;
  logic [31:0] wb_pc;
  logic [5:0]  int_in;
  logic        rf_wen;
  logic [4:0]  rf_wdest;
  logic [31:0] rf_wdata;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        cancel;
  logic [9:0]  hist_dest;
  logic [31:0] hi_data, lo_data;
  logic        int_pending;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];
  logic [9:0]  histQ[$];
  logic [31:0] expVal;
  logic [9:0]  expHist;

  always #5 clk = ~clk;

  wb_cp0_unit #(
    .EXC_VECTOR(32'h0000_0000), .N_INT(6), .HIST_DEPTH(2), .TIMER_EN(1)
  ) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_wen(wb_wen),
    .wb_wdest(wb_wdest), .wb_result(wb_result), .wb_lo_result(wb_lo_result),
    .hi_write(hi_write), .lo_write(lo_write), .mfhi(mfhi), .mflo(mflo),
    .mfc0(mfc0), .mtc0(mtc0), .cp0_addr(cp0_addr), .exc_in(exc_in),
    .exc_code_in(exc_code_in), .bad_vaddr(bad_vaddr), .eret(eret), .wb_pc(wb_pc),
    .int_in(int_in), .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .cancel(cancel), .hist_dest(hist_dest),
    .hi_data(hi_data), .lo_data(lo_data), .int_pending(int_pending)
  );

  task automatic clearInputs();
    wb_valid = 0; wb_wen = 0; wb_wdest = 0; wb_result = 0; wb_lo_result = 0;
    hi_write = 0; lo_write = 0; mfhi = 0; mflo = 0; mfc0 = 0; mtc0 = 0;
    cp0_addr = 0; exc_in = 0; exc_code_in = 0; bad_vaddr = 0; eret = 0; wb_pc = 0;
  endtask

  task automatic readCp0(input logic [4:0] regNum, input logic [31:0] expected);
    clearInputs();
    wb_valid = 1; mfc0 = 1; wb_wen = 1; cp0_addr = {regNum, 3'b000};
    expQ.push_back(expected);
  endtask

  task automatic writeCp0(input logic [4:0] regNum, input logic [31:0] value);
    clearInputs();
    wb_valid = 1; mtc0 = 1; cp0_addr = {regNum, 3'b000}; wb_result = value;
  endtask

  task automatic test_reset();
    resetn = 0;
    clearInputs();
    wb_valid = 1; exc_in = 1; wb_wen = 1; wb_wdest = 5'd3;
    @(negedge clk);
    #1;
    checks++; if (exc_valid !== 1'b0 || cancel !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_redirect got exc_valid=%b cancel=%b exp 0 0", exc_valid, cancel); end
    checks++; if (rf_wen !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_rf_wen got %b exp 0", rf_wen); end
    checks++; if (hist_dest !== 10'd0 || hi_data !== 32'd0 || lo_data !== 32'd0) begin errors++;
      $display("[TB] FAIL reset_state got hist=%h hi=%h lo=%h exp 0", hist_dest, hi_data, lo_data); end
    checks++; if (int_pending !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_int_pending got %b exp 0", int_pending); end
    @(negedge clk);
    resetn = 1;
    readCp0(5'd12, 32'h0);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL reset_status got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd14, 32'h0);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL reset_epc got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
  endtask

  task automatic test_retire();
    clearInputs();
    wb_valid = 1; wb_wen = 1; wb_wdest = 5'd5; wb_result = 32'h1234;
    histQ.push_back(10'h005); histQ.push_back(10'h0A0); histQ.push_back(10'h000);
    #1;
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h1234 || rf_wdest !== 5'd5) begin errors++;
      $display("[TB] FAIL retire_write got wen=%b dest=%0d data=%h exp 1 5 00001234", rf_wen, rf_wdest, rf_wdata); end
    checks++; if (exc_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL retire_no_redirect got %b exp 0", exc_valid); end
    @(negedge clk);
    clearInputs();
    wb_valid = 1; wb_wen = 1; wb_wdest = 5'd0; wb_result = 32'h55;
    #1; expHist = histQ.pop_front();
    checks++; if (hist_dest !== expHist) begin errors++;
      $display("[TB] FAIL hist_slot0 got %h exp %h", hist_dest, expHist); end
    @(negedge clk);
    clearInputs();
    wb_wen = 1; wb_wdest = 5'd6;
    #1; expHist = histQ.pop_front();
    checks++; if (hist_dest !== expHist) begin errors++;
      $display("[TB] FAIL hist_slot1 got %h exp %h", hist_dest, expHist); end
    checks++; if (rf_wen !== 1'b0) begin errors++;
      $display("[TB] FAIL invalid_no_write got %b exp 0", rf_wen); end
    @(negedge clk);
    clearInputs();
    #1; expHist = histQ.pop_front();
    checks++; if (hist_dest !== expHist) begin errors++;
      $display("[TB] FAIL hist_drain got %h exp %h", hist_dest, expHist); end
    @(negedge clk);
  endtask

  task automatic test_exception();
    clearInputs();
    wb_valid = 1; exc_in = 1; exc_code_in = 5'd4; bad_vaddr = 32'h1233;
    wb_pc = 32'h100; wb_wen = 1; wb_wdest = 5'd7;
    #1;
    checks++; if (rf_wen !== 1'b0 || exc_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL adel_trap got wen=%b exc_valid=%b exp 0 1", rf_wen, exc_valid); end
    @(negedge clk);
    clearInputs();
    wb_valid = 1; exc_in = 1; exc_code_in = 5'd12; wb_pc = 32'hBFC0_0100;
    bad_vaddr = 32'h9999; mtc0 = 1; cp0_addr = {5'd14, 3'b000}; wb_result = 32'hDEAD;
    wb_wen = 1; wb_wdest = 5'd8;
    #1;
    checks++; if (rf_wen !== 1'b0 || cancel !== 1'b1 || exc_pc !== 32'h0) begin errors++;
      $display("[TB] FAIL ov_trap got wen=%b cancel=%b pc=%h exp 0 1 00000000", rf_wen, cancel, exc_pc); end
    checks++; if (hist_dest[4:0] !== 5'd0) begin errors++;
      $display("[TB] FAIL trap_hist got %0d exp 0", hist_dest[4:0]); end
    @(negedge clk);
    readCp0(5'd14, 32'hBFC0_0100);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL exc_epc got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd13, 32'h30);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL exc_cause got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd12, 32'h2);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL exc_status got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd8, 32'h1233);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL badvaddr got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd12, 32'h0);
    cp0_addr = {5'd12, 3'b001};
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL unmapped_sel got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
  endtask

  task automatic test_eret();
    writeCp0(5'd14, 32'h40);
    @(negedge clk);
    clearInputs();
    wb_valid = 1; eret = 1; wb_wen = 1; wb_wdest = 5'd4;
    #1;
    checks++; if (exc_pc !== 32'h40 || cancel !== 1'b1 || exc_valid !== 1'b1 || rf_wen !== 1'b0) begin errors++;
      $display("[TB] FAIL eret_redirect got pc=%h cancel=%b valid=%b wen=%b exp 00000040 1 1 0",
               exc_pc, cancel, exc_valid, rf_wen); end
    @(negedge clk);
    readCp0(5'd12, 32'h0);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL eret_status got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
  endtask

  task automatic test_interrupt();
    int_in = 6'd0;
    writeCp0(5'd12, 32'h0401);
    @(negedge clk);
    clearInputs();
    int_in = 6'b000100;
    #1;
    checks++; if (int_pending !== 1'b0) begin errors++;
      $display("[TB] FAIL int_unsampled got %b exp 0", int_pending); end
    @(negedge clk);
    #1;
    checks++; if (int_pending !== 1'b1) begin errors++;
      $display("[TB] FAIL int_pending got %b exp 1", int_pending); end
    clearInputs();
    wb_valid = 1; wb_wen = 1; wb_wdest = 5'd9; wb_result = 32'h77; wb_pc = 32'h2000;
    exc_in = 1; exc_code_in = 5'd12;
    #1;
    checks++; if (rf_wen !== 1'b0 || exc_valid !== 1'b1 || exc_pc !== 32'h0) begin errors++;
      $display("[TB] FAIL int_take got wen=%b valid=%b pc=%h exp 0 1 00000000", rf_wen, exc_valid, exc_pc); end
    @(negedge clk);
    #1;
    checks++; if (int_pending !== 1'b0) begin errors++;
      $display("[TB] FAIL int_masked_by_exl got %b exp 0", int_pending); end
    readCp0(5'd13, 32'h400);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL int_cause got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd14, 32'h2000);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL int_epc got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    int_in = 6'd0;
    writeCp0(5'd12, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_timer();
    logic [31:0] expCause;
    writeCp0(5'd9, 32'd10);
    @(negedge clk);
    writeCp0(5'd11, 32'd20);
    @(negedge clk);
    readCp0(5'd9, 32'd11);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL count_load got %0d exp %0d", rf_wdata, expVal); end
    @(negedge clk);
    // Count reaches 20 at step 9; TI follows one edge later and IP7 one edge after that.
    for (int i = 1; i <= 12; i++) begin
      expCause = 32'h0;
      if (i >= 10) expCause[30] = 1'b1;
      if (i >= 11) expCause[13] = 1'b1;
      readCp0(5'd13, expCause);
      #1; expVal = expQ.pop_front();
      checks++; if (rf_wdata !== expVal) begin errors++;
        $display("[TB] FAIL timer_cause step %0d got %h exp %h", i, rf_wdata, expVal); end
      @(negedge clk);
    end
    writeCp0(5'd11, 32'd100);
    @(negedge clk);
    readCp0(5'd13, 32'h2000);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL ti_cleared got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    readCp0(5'd13, 32'h0);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL ip7_cleared got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
  endtask

  task automatic test_hilo_and_reset();
    clearInputs();
    wb_valid = 1; hi_write = 1; lo_write = 1; wb_result = 32'hAAAA; wb_lo_result = 32'h5555;
    @(negedge clk);
    clearInputs();
    wb_valid = 1; exc_in = 1; exc_code_in = 5'd12; hi_write = 1; wb_result = 32'hBBBB;
    #1;
    checks++; if (hi_data !== 32'hAAAA || lo_data !== 32'h5555) begin errors++;
      $display("[TB] FAIL hilo_write got hi=%h lo=%h exp 0000aaaa 00005555", hi_data, lo_data); end
    @(negedge clk);
    clearInputs();
    wb_valid = 1; mfhi = 1; wb_wen = 1; wb_wdest = 5'd3;
    expQ.push_back(32'hAAAA);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL mfhi got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    clearInputs();
    wb_valid = 1; mflo = 1; wb_wen = 1; wb_wdest = 5'd3;
    expQ.push_back(32'h5555);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL mflo got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    writeCp0(5'd14, 32'h1234_5678);
    @(negedge clk);
    readCp0(5'd14, 32'h1234_5678);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL epc_write got %h exp %h", rf_wdata, expVal); end
    @(negedge clk);
    clearInputs();
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    readCp0(5'd14, 32'h0);
    #1; expVal = expQ.pop_front();
    checks++; if (rf_wdata !== expVal) begin errors++;
      $display("[TB] FAIL epc_after_reset got %h exp %h", rf_wdata, expVal); end
    checks++; if (hi_data !== 32'h0 || lo_data !== 32'h0) begin errors++;
      $display("[TB] FAIL hilo_after_reset got hi=%h lo=%h exp 0 0", hi_data, lo_data); end
    @(negedge clk);
  endtask

  initial begin
    resetn = 0;
    int_in = 6'd0;
    clearInputs();
    test_reset();
    test_retire();
    test_exception();
    test_eret();
    test_interrupt();
    test_timer();
    test_hilo_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cp0_unit.md
Name: wb_cp0_unit

Overview:
- Parametrised successor of the five-stage pipeline's write-back stage.
- Retires MEM->WB results into the register file and HI/LO.
- Hosts an extended CP0: Status, Cause, EPC, Count, Compare; multiple exception codes; masked hardware interrupts; timer interrupt.
- Exports a configurable-depth retired-destination history for hazard checking in decode, replacing the fixed two-cycle delay.

Parameters:
- EXC_VECTOR, 32'h0000_0000, exception entry PC for all exceptions and interrupts.
- N_INT, 6, number of external interrupt lines (1..6); occupies IP/IM bits [8+N_INT-1:8].
- HIST_DEPTH, 2, number of past retired destinations exported (1..4).
- TIMER_EN, 1, 1 = Count/Compare implemented; 0 = both read 0, TI never set.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_wen  in  1  instruction writes GPR
- wb_wdest  in  5  GPR destination
- wb_result  in  32  main result; HI data when hi_write; mtc0 data
- wb_lo_result  in  32  LO data
- hi_write, lo_write  in  1 each  HI/LO write enables
- mfhi, mflo, mfc0, mtc0  in  1 each  move-instruction flags
- cp0_addr  in  8  {reg[4:0], sel[2:0]}
- exc_in  in  1  upstream-detected exception (overflow, address error, syscall, break)
- exc_code_in  in  5  ExcCode for exc_in
- bad_vaddr  in  32  faulting address, valid when exc_code_in is 4 or 5
- eret  in  1  ERET in WB
- wb_pc  in  32  PC of the WB instruction
- int_in  in  N_INT  level-sensitive external interrupts
- rf_wen  out  1  GPR write enable
- rf_wdest  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- exc_valid  out  1  redirect fetch this cycle
- exc_pc  out  32  redirect target
- cancel  out  1  flush IF..MEM
- hist_dest  out  5*HIST_DEPTH  retired destinations; slot k at bits [5k+4:5k]; 0 = none
- hi_data, lo_data  out  32 each  HI/LO contents
- int_pending  out  1  unmasked interrupt pending, gated by IE and !EXL

Behaviour:
- Reset is synchronous, active-low resetn on clk. At reset:
  - HI, LO, EPC, BadVAddr, Count, Compare = 0.
  - Status: EXL = 0, IE = 0, IM = 0.
  - Cause: ExcCode = 0, TI = 0.
  - hist_dest all 0.
  - Outputs: rf_wen = 0, exc_valid = 0, cancel = 0.
- Event priority, evaluated only when wb_valid = 1:
  - int_take = IE & !EXL & |(IP & IM) has highest priority.
  - Then exc_in.
  - Then eret.
  - Then normal retire.
- int_take or exc_in (trap):
  - rf_wen = 0; HI/LO and mtc0 writes are suppressed.
  - Next edge: EPC <= wb_pc, EXL <= 1, ExcCode <= 0 for interrupt or exc_code_in for exception.
  - BadVAddr <= bad_vaddr when code is 4 or 5.
  - Same cycle (combinational): exc_valid = cancel = 1, exc_pc = EXC_VECTOR.
- eret: next edge EXL <= 0. Same cycle: exc_valid = cancel = 1, exc_pc = current EPC; rf_wen = 0.
- Normal retire:
  - rf_wen = wb_wen.
  - rf_wdata priority: mfhi ? HI : mflo ? LO : mfc0 ? cp0_rdata : wb_result.
  - HI <= wb_result on hi_write; LO <= wb_lo_result on lo_write.
  - mtc0 writes the addressed CP0 register next edge.
- CP0 map (sel = 0; all other addresses read 0, writes ignored):
  - 8 BadVAddr: read-only.
  - 9 Count: read/write.
  - 11 Compare: read/write; any write clears TI.
  - 12 Status: bit0 IE, bit1 EXL, IM bits; rest read 0.
  - 13 Cause: bit30 TI, IP[8+N_INT-1:8] read-only, ExcCode[6:2]; rest read 0.
  - 14 EPC: read/write.
- IP is sampled every cycle: IP <= int_in, with IP[7+N_INT] replaced by (int_in | TI) for that bit.
- Timer:
  - Count increments by 1 every cycle, wrapping at 2^32.
  - An mtc0 to Count loads the written value instead of incrementing that cycle.
  - TI is set the edge after Count == Compare (Compare != 0 or Count wrapped); it stays set until Compare is written.
- Simultaneous updates in one edge:
  - Trap and mtc0 in the same instruction: trap wins.
  - Trap sets EXL regardless of eret (they cannot co-occur; exc_in has priority).
- hist_dest is a shift register clocked every cycle:
  - slot0 <= (wb_valid & rf_wen & wdest != 0) ? wdest : 0.
  - slot k <= slot k-1.
  - It is not cleared by cancel.
- All outputs except the history and CP0-sourced reads are combinational from the WB inputs; CP0 state updates take effect on the next edge.
- Reset mid-trap: CP0 returns to reset values and the pending redirect is dropped.

Test Plan:
- Retire addi, wb_wdest=5, wb_result=0x1234 -> rf_wen=1, rf_wdata=0x1234; slot0=5 next cycle, slot1=5 one cycle later, then 0 with HIST_DEPTH=2.
- exc_in=1, exc_code_in=12, wb_pc=0xBFC00100 -> rf_wen=0, exc_pc=EXC_VECTOR, cancel=1; next cycle EPC=0xBFC00100, Cause=0x30, Status.EXL=1.
- mtc0 Status=0x0401 (IE, IM2), then int_in[2]=1 with a valid add in WB -> trap, ExcCode=0, add not written; int_pending=0 after the trap (EXL=1).
- mtc0 Compare=20 at Count=10 -> TI=1 at the edge after Count==20; IP7 set; mtc0 Compare=100 -> TI=0.
- eret with EPC=0x40 -> exc_pc=0x40, cancel=1, EXL cleared next cycle; mfc0 Status returns bit1 = 0.
- hi_write with wb_result=0xAAAA and lo_write with wb_lo_result=0x5555 in the same instruction, then mfhi and mflo -> 0xAAAA and 0x5555; assert resetn=0 while EPC is set -> EPC=0 next cycle.
